if_id_pipe_chain: RTL

//   Parametrised fetch->decode pipeline register chain: successor to the single-stage IF/ID latch.

---
 rtl/if_id_pipe_chain.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/if_id_pipe_chain.sv
// Fetch->decode register chain of DEPTH stages with global stall/flush and
// saturating perf counters for flushed instructions and stalled-valid cycles.
module if_id_pipe_chain #(
  parameter int                PC_W     = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 1,
  parameter logic [INST_W-1:0] NOP_INST = {INST_W{1'b0}},
  parameter int                CNT_W    = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [PC_W-1:0]   addedPC_i,
  input  logic [INST_W-1:0] inst_i,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic [PC_W-1:0]   addedPC_o,
  output logic [INST_W-1:0] inst_o,
  output logic              valid_o,
  output logic [CNT_W-1:0]  flush_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_depth_check
    $error("if_id_pipe_chain: DEPTH must be in 1..4");
  end

  if (CNT_W < 3) begin : g_cnt_check
    $error("if_id_pipe_chain: CNT_W must be at least 3");
  end

  typedef enum logic [1:0] {
    OP_ADVANCE = 2'd0,
    OP_STALL   = 2'd1,
    OP_FLUSH   = 2'd2
  } op_e;

  logic              valid_r [DEPTH];
  logic [PC_W-1:0]   pc_r    [DEPTH];
  logic [INST_W-1:0] inst_r  [DEPTH];
  logic [CNT_W-1:0]  flush_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  op_e               op_s;
  logic [PC_W-1:0]   cap_pc_s;
  logic [INST_W-1:0] cap_inst_s;
  logic [2:0]        valid_cnt_s;
  logic [2:0]        flush_add_s;
  logic              stall_hit_s;

  // Saturating add of a small increment; the result never wraps past all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                               input logic [2:0]       inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W-2){1'b0}}, inc};
    if (sum > {1'b0, {CNT_W{1'b1}}}) begin
      sat_add = {CNT_W{1'b1}};
    end else begin
      sat_add = sum[CNT_W-1:0];
    end
  endfunction

  // Per-edge operation: flush beats stall, stall beats advance.
  always_comb begin
    if (flush_i) begin
      op_s = OP_FLUSH;
    end else if (stall_i) begin
      op_s = OP_STALL;
    end else begin
      op_s = OP_ADVANCE;
    end
  end

  // Capture value for stage 0; an invalid fetch slot enters as a clean bubble.
  always_comb begin
    if (valid_i) begin
      cap_pc_s   = addedPC_i;
      cap_inst_s = inst_i;
    end else begin
      cap_pc_s   = {PC_W{1'b0}};
      cap_inst_s = NOP_INST;
    end
  end

  // Number of real instructions a flush would squash this edge (stages plus fetch slot).
  always_comb begin
    valid_cnt_s = 3'd0;
    for (int k = 0; k < DEPTH; k++) begin
      valid_cnt_s = valid_cnt_s + {2'b00, valid_r[k]};
    end
    flush_add_s = valid_cnt_s + {2'b00, valid_i};
    stall_hit_s = (op_s == OP_STALL) && valid_r[DEPTH-1];
  end

  // Stage chain registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        valid_r[k] <= 1'b0;
        pc_r[k]    <= {PC_W{1'b0}};
        inst_r[k]  <= NOP_INST;
      end
    end else begin
      case (op_s)
        OP_FLUSH: begin
          for (int k = 0; k < DEPTH; k++) begin
            valid_r[k] <= 1'b0;
            pc_r[k]    <= {PC_W{1'b0}};
            inst_r[k]  <= NOP_INST;
          end
        end
        OP_ADVANCE: begin
          valid_r[0] <= valid_i;
          pc_r[0]    <= cap_pc_s;
          inst_r[0]  <= cap_inst_s;
          for (int k = 1; k < DEPTH; k++) begin
            valid_r[k] <= valid_r[k-1];
            pc_r[k]    <= pc_r[k-1];
            inst_r[k]  <= inst_r[k-1];
          end
        end
        default: begin
          for (int k = 0; k < DEPTH; k++) begin
            valid_r[k] <= valid_r[k];
            pc_r[k]    <= pc_r[k];
            inst_r[k]  <= inst_r[k];
          end
        end
      endcase
    end
  end

  // Perf counters; a combined flush+stall edge counts only as a flush.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      flush_cnt_r <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (op_s == OP_FLUSH) begin
        flush_cnt_r <= sat_add(flush_cnt_r, flush_add_s);
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
      if (stall_hit_s) begin
        stall_cnt_r <= sat_add(stall_cnt_r, 3'd1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign valid_o     = valid_r[DEPTH-1];
  assign addedPC_o   = pc_r[DEPTH-1];
  assign inst_o      = inst_r[DEPTH-1];
  assign flush_cnt_o = flush_cnt_r;
  assign stall_cnt_o = stall_cnt_r;

endmodule
